// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // 10**n, used to build the saturation threshold at elaboration time
    function automatic int unsigned pow10(input int unsigned n);
        int unsigned p;
        p = 1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between a producer of binary values and bin2bcd_seq.
interface bin2bcd_seq_if #(
    parameter int unsigned WIDTH  = 10,
    parameter int unsigned DIGITS = 4
);
    import bin2bcd_pkg::*;

    logic                          start;
    logic [WIDTH-1:0]              bin;
    logic                          busy;
    logic                          done;
    logic [BCD_DIGIT_W*DIGITS-1:0] bcd;
    logic                          overflow;
    logic [DIGITS-1:0]             blank;

    modport master (output start, bin, input busy, done, bcd, overflow, blank);
    modport slave  (input start, bin, output busy, done, bcd, overflow, blank);

endinterface

// File: rtl/bin2bcd_seq_dabble_digit.sv
// One double-dabble digit correction: add 3 to a BCD nibble holding 5 or more.
module dabble_digit
    import bin2bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adjusted
);

    assign adjusted = (digit >= BCD_DIGIT_W'(5)) ? digit + BCD_DIGIT_W'(3) : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 binary-to-BCD converter, one input bit per clock.
// Define BIN2BCD_BLANK_EN to generate per-digit leading-zero blank requests.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 10,
    parameter int unsigned DIGITS = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    bin2bcd_seq_if.slave bus
);

    localparam int unsigned SCR_W   = BCD_DIGIT_W * DIGITS;
    localparam int unsigned CNT_W   = $clog2(WIDTH + 1);
    localparam logic [31:0] MAX_VAL = 32'(pow10(DIGITS) - 1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [SCR_W-1:0] scratch;
    logic [CNT_W-1:0] cnt;
    logic             ovf_pending;
    logic             busy_q;
    logic             done_q;
    logic             ovf_q;
    logic [SCR_W-1:0] bcd_q;

    logic [SCR_W-1:0]       adjusted_c;
    logic [SCR_W+WIDTH-1:0] shifted_c;
    logic [SCR_W-1:0]       result_c;

    for (genvar k = 0; k < DIGITS; k++) begin : g_dabble
        dabble_digit u_digit (
            .digit    (scratch[k*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .adjusted (adjusted_c[k*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign shifted_c = {adjusted_c, shreg} << 1;
    // Out-of-range inputs saturate to all nines instead of showing truncated digits
    assign result_c  = ovf_pending ? {DIGITS{4'h9}} : scratch;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            shreg       <= '0;
            scratch     <= '0;
            cnt         <= '0;
            ovf_pending <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            bcd_q       <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shreg       <= bus.bin;
                        scratch     <= '0;
                        cnt         <= CNT_W'(WIDTH);
                        ovf_pending <= (32'(bus.bin) > MAX_VAL);
                        busy_q      <= 1'b1;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    {scratch, shreg} <= shifted_c;
                    cnt              <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bcd_q  <= result_c;
                    ovf_q  <= ovf_pending;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd      = bcd_q;
    assign bus.overflow = ovf_q;

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank_c;
    logic [DIGITS-1:0] blank_q;
    logic              leading;

    // Blank every zero digit above the most significant nonzero one; digit 0 always shows
    always_comb begin
        blank_c = '0;
        leading = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (result_c[k*BCD_DIGIT_W +: BCD_DIGIT_W] != 4'h0) begin
                leading = 1'b0;
            end
            blank_c[k] = leading;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blank_q <= '0;
        end else if (state == DONE) begin
            blank_q <= blank_c;
        end
    end

    assign bus.blank = blank_q;
`else
    assign bus.blank = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench: 4-digit and 3-digit converters fed identical stimulus.
module tb_bin2bcd_seq;
    import bin2bcd_pkg::*;

    localparam int unsigned WIDTH   = 10;
    localparam int          LATENCY = WIDTH + 1;
`ifdef BIN2BCD_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;

    bin2bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(4)) if4 ();
    bin2bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(3)) if3 ();

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(4)) dut4 (.clk(clk), .reset_n(reset_n), .bus(if4.slave));
    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(3)) dut3 (.clk(clk), .reset_n(reset_n), .bus(if3.slave));

    always #5 clk = ~clk;

    // Reference: decimal digits by division, saturated to 10^digits-1
    function automatic logic [19:0] ref_bcd(input int unsigned v, input int unsigned digits);
        logic [19:0] r;
        int unsigned x;
        r = '0;
        x = (v > pow10(digits) - 1) ? pow10(digits) - 1 : v;
        for (int k = 0; k < int'(digits); k++) begin
            r[k*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] ref_blank(input int unsigned v, input int unsigned digits);
        logic [4:0]  b;
        int unsigned x;
        int          nd;
        b  = '0;
        x  = v;
        nd = 1;
        while (x >= 10) begin
            x  = x / 10;
            nd = nd + 1;
        end
        for (int k = 0; k < int'(digits); k++) begin
            if (k >= nd && v <= pow10(digits) - 1) b[k] = BLANK_EN;
        end
        return b;
    endfunction

    function automatic bit nibbles_ok(input logic [19:0] b, input int unsigned digits);
        bit ok;
        ok = 1'b1;
        for (int k = 0; k < int'(digits); k++) begin
            if (b[k*4 +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Called at a negedge; returns at the following negedge with start released
    task automatic issue(input int unsigned v);
        if4.start = 1'b1; if4.bin = WIDTH'(v);
        if3.start = 1'b1; if3.bin = WIDTH'(v);
        @(negedge clk);
        if4.start = 1'b0;
        if3.start = 1'b0;
    endtask

    task automatic wait_done(output int cycles, output int busy_cycles);
        cycles      = 0;
        busy_cycles = if4.busy ? 1 : 0;
        while (!if4.done && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (if4.busy) busy_cycles++;
        end
        if (!if4.done) cycles = -1;
    endtask

    task automatic verify(input string tag, input int unsigned v);
        logic [19:0] exp4, exp3;
        exp4 = ref_bcd(v, 4);
        exp3 = ref_bcd(v, 3);
        check({tag, " bcd4"},  32'(if4.bcd), 32'(exp4[15:0]));
        check({tag, " ovf4"},  32'(if4.overflow), 32'(v > 9999));
        check({tag, " blank4"}, 32'(if4.blank), 32'(ref_blank(v, 4) & 5'h0f));
        check({tag, " bcd3"},  32'(if3.bcd), 32'(exp3[11:0]));
        check({tag, " ovf3"},  32'(if3.overflow), 32'(v > 999));
        check({tag, " blank3"}, 32'(if3.blank), 32'(ref_blank(v, 3) & 5'h07));
        check({tag, " done3"}, 32'(if3.done), 32'(1));
        check({tag, " digits<=9"}, 32'(nibbles_ok({4'h0, if4.bcd}, 4) && nibbles_ok({8'h0, if3.bcd}, 3)), 32'(1));
    endtask

    typedef struct {
        int unsigned v;
        logic [15:0] bcd4;
        logic [11:0] bcd3;
        logic        ovf3;
    } vec_t;

    initial begin
        vec_t vecs[9];
        int   cyc, bcyc, ndone;
        int unsigned rv;

        vecs[0] = '{0,    16'h0000, 12'h000, 1'b0};
        vecs[1] = '{999,  16'h0999, 12'h999, 1'b0};
        vecs[2] = '{1023, 16'h1023, 12'h999, 1'b1};
        vecs[3] = '{42,   16'h0042, 12'h042, 1'b0};
        vecs[4] = '{1000, 16'h1000, 12'h999, 1'b1};
        vecs[5] = '{512,  16'h0512, 12'h512, 1'b0};
        vecs[6] = '{100,  16'h0100, 12'h100, 1'b0};
        vecs[7] = '{5,    16'h0005, 12'h005, 1'b0};
        vecs[8] = '{59,   16'h0059, 12'h059, 1'b0};

        if4.start = 1'b0; if4.bin = '0;
        if3.start = 1'b0; if3.bin = '0;
        repeat (3) @(negedge clk);
        check("reset busy",  32'(if4.busy), 32'(0));
        check("reset done",  32'(if4.done), 32'(0));
        check("reset bcd",   32'(if4.bcd), 32'(0));
        check("reset ovf",   32'(if3.overflow), 32'(0));
        check("reset blank", 32'(if4.blank), 32'(0));
        reset_n = 1'b1;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].v);
            check("busy after accept", 32'(if4.busy), 32'(1));
            wait_done(cyc, bcyc);
            check("latency", 32'(cyc), 32'(LATENCY));
            check("busy cycles", 32'(bcyc), 32'(LATENCY));
            check("tbl bcd4", 32'(if4.bcd), 32'(vecs[i].bcd4));
            check("tbl bcd3", 32'(if3.bcd), 32'(vecs[i].bcd3));
            check("tbl ovf3", 32'(if3.overflow), 32'(vecs[i].ovf3));
            check("tbl ovf4", 32'(if4.overflow), 32'(0));
            check("tbl blank4", 32'(if4.blank), 32'(ref_blank(vecs[i].v, 4) & 5'h0f));
            @(negedge clk);
            check("done one cycle", 32'(if4.done), 32'(0));
            check("held bcd4", 32'(if4.bcd), 32'(vecs[i].bcd4));
        end

        // Start while busy is ignored, then a start in the done cycle is taken
        issue(512);
        repeat (3) @(negedge clk);
        if4.start = 1'b1; if4.bin = WIDTH'(7);
        if3.start = 1'b1; if3.bin = WIDTH'(7);
        @(negedge clk);
        if4.start = 1'b0; if3.start = 1'b0;
        check("mid bcd unchanged", 32'(if4.bcd), 32'(16'h0059));
        wait_done(cyc, bcyc);
        check("ignored start bcd4", 32'(if4.bcd), 32'(16'h0512));
        issue(7);
        wait_done(cyc, bcyc);
        check("back-to-back latency", 32'(cyc), 32'(LATENCY));
        check("back-to-back bcd4", 32'(if4.bcd), 32'(16'h0007));
        ndone = 0;
        repeat (15) begin
            @(negedge clk);
            if (if4.done) ndone++;
        end
        check("no queued start", 32'(ndone), 32'(0));

        // Reset in the middle of a conversion
        issue(1023);
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midreset busy", 32'(if4.busy), 32'(0));
        check("midreset bcd",  32'(if4.bcd), 32'(0));
        check("midreset done", 32'(if4.done), 32'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (if4.done) ndone++;
        end
        check("no done after reset", 32'(ndone), 32'(0));
        check("bcd stays 0", 32'(if4.bcd), 32'(0));
        issue(250);
        wait_done(cyc, bcyc);
        check("post-reset latency", 32'(cyc), 32'(LATENCY));
        check("post-reset bcd4", 32'(if4.bcd), 32'(16'h0250));
        @(negedge clk);

        // start held high: one conversion every WIDTH+2 cycles
        if4.start = 1'b1; if4.bin = WIDTH'(300);
        if3.start = 1'b1; if3.bin = WIDTH'(300);
        @(negedge clk);
        wait_done(cyc, bcyc);
        @(negedge clk);
        wait_done(cyc, bcyc);
        if4.start = 1'b0; if3.start = 1'b0;
        check("continuous period", 32'(cyc + 1), 32'(WIDTH + 2));
        verify("continuous", 300);
        @(negedge clk);
        check("idle after continuous", 32'(if4.busy), 32'(0));

        // Exhaustive sweep, then random values
        for (int v = 0; v < 1024; v++) begin
            issue(v);
            wait_done(cyc, bcyc);
            check("sweep latency", 32'(cyc), 32'(LATENCY));
            verify("sweep", v);
        end
        for (int i = 0; i < 100; i++) begin
            rv = $urandom_range(0, 1023);
            issue(rv);
            wait_done(cyc, bcyc);
            check("rand latency", 32'(cyc), 32'(LATENCY));
            verify("rand", rv);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
